// File: rtl/init_sweep_ctrl.sv
// Sweeps initial values start_val..end_val (modulo 2^W) through an external
// gene network, tallying how many settle to a fixed point versus a cycle.
module init_sweep_ctrl #(
  parameter int W  = 8,
  parameter int CW = W + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  input  logic [W-1:0]  start_val,
  input  logic [W-1:0]  end_val,
  input  logic          fixed,
  input  logic          cycle,
  output logic [W-1:0]  init_val,
  output logic          load,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] fixed_cnt,
  output logic [CW-1:0] cycle_cnt
);

  typedef enum logic [1:0] {IDLE, LOAD, WAIT, DONE} state_t;

  state_t        state_reg, state_next;
  logic [W-1:0]  init_val_reg, init_val_next;
  logic [W-1:0]  end_reg, end_next;
  logic [CW-1:0] fixed_cnt_reg, fixed_cnt_next;
  logic [CW-1:0] cycle_cnt_reg, cycle_cnt_next;
  logic          load_reg, load_next;
  logic          busy_reg, busy_next;
  logic          done_reg, done_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      init_val_reg  <= '0;
      end_reg       <= '0;
      fixed_cnt_reg <= '0;
      cycle_cnt_reg <= '0;
      load_reg      <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      init_val_reg  <= init_val_next;
      end_reg       <= end_next;
      fixed_cnt_reg <= fixed_cnt_next;
      cycle_cnt_reg <= cycle_cnt_next;
      load_reg      <= load_next;
      busy_reg      <= busy_next;
      done_reg      <= done_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    init_val_next  = init_val_reg;
    end_next       = end_reg;
    fixed_cnt_next = fixed_cnt_reg;
    cycle_cnt_next = cycle_cnt_reg;

    case (state_reg)
      IDLE: begin
        // abort is meaningless here, so start wins even when both are high
        if (start) begin
          state_next     = LOAD;
          init_val_next  = start_val;
          end_next       = end_val;
          fixed_cnt_next = '0;
          cycle_cnt_next = '0;
        end
      end
      LOAD: begin
        state_next = abort ? IDLE : WAIT;
      end
      WAIT: begin
        if (abort) begin
          state_next = IDLE;
        end else if (fixed || cycle) begin
          if (fixed) fixed_cnt_next = fixed_cnt_reg + CW'(1);
          else       cycle_cnt_next = cycle_cnt_reg + CW'(1);
          if (init_val_reg == end_reg) begin
            state_next = DONE;
          end else begin
            init_val_next = init_val_reg + W'(1);
            state_next    = LOAD;
          end
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Flags are derived from the upcoming state so they register in step with it
  always_comb begin
    load_next = (state_next == LOAD);
    busy_next = (state_next != IDLE);
    done_next = (state_next == DONE);
  end

  assign init_val  = init_val_reg;
  assign load      = load_reg;
  assign busy      = busy_reg;
  assign done      = done_reg;
  assign fixed_cnt = fixed_cnt_reg;
  assign cycle_cnt = cycle_cnt_reg;

endmodule

// File: tb/tb_init_sweep_ctrl.sv
// Directed bench for init_sweep_ctrl: expected init values are queued when a
// sweep is launched and popped as the DUT raises load.
module tb_init_sweep_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic [7:0] start_val;
  logic [7:0] end_val;
  logic       fixed;
  logic       cycle;
  logic [7:0] init_val;
  logic       load;
  logic       busy;
  logic       done;
  logic [8:0] fixed_cnt;
  logic [8:0] cycle_cnt;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];

  init_sweep_ctrl #(.W(8), .CW(9)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .start_val (start_val),
    .end_val   (end_val),
    .fixed     (fixed),
    .cycle     (cycle),
    .init_val  (init_val),
    .load      (load),
    .busy      (busy),
    .done      (done),
    .fixed_cnt (fixed_cnt),
    .cycle_cnt (cycle_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // result pattern: 0 all fixed, 1 all cycle, 2 both flags, 3 fixed/cycle alternating
  function automatic logic [1:0] res_for(input int mode, input int idx);
    case (mode)
      0:       return 2'b10;
      1:       return 2'b01;
      2:       return 2'b11;
      default: return (idx % 2 == 0) ? 2'b10 : 2'b01;
    endcase
  endfunction

  task automatic wait_load(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (load === 1'b1) begin
        ok = 1'b1;
        return;
      end
      step();
    end
    chk("load_timeout", 32'd0, 32'd1);
  endtask

  task automatic sweep(input logic [7:0] sv, input logic [7:0] ev, input int mode,
                       input int extra, input logic abort_with_start);
    logic [7:0] d;
    logic [1:0] r;
    int n;
    int ef = 0;
    int ec = 0;
    int loads = 0;
    int idx = 0;
    bit ok;
    d = ev - sv;
    n = int'(d) + 1;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(sv + 8'(i));
      r = res_for(mode, i);
      if (r[1]) ef++;
      else if (r[0]) ec++;
    end
    start_val = sv;
    end_val   = ev;
    start     = 1'b1;
    abort     = abort_with_start;
    step();
    start = 1'b0;
    abort = 1'b0;
    while (exp_q.size() > 0) begin
      wait_load(ok);
      if (!ok) begin
        exp_q.delete();
        return;
      end
      loads++;
      chk($sformatf("init_val[%0d]", idx), 32'(init_val), 32'(exp_q.pop_front()));
      step();
      chk("load_one_cycle", 32'(load), 32'd0);
      for (int e = 0; e < extra; e++) begin
        step();
        chk("wait_hold", 32'({busy, load}), 32'b10);
      end
      r = res_for(mode, idx);
      idx++;
      {fixed, cycle} = r;
      step();
      fixed = 1'b0;
      cycle = 1'b0;
    end
    chk("done_pulse", 32'(done), 32'd1);
    chk("fixed_cnt", 32'(fixed_cnt), 32'(ef));
    chk("cycle_cnt", 32'(cycle_cnt), 32'(ec));
    chk("load_count", 32'(loads), 32'(n));
    step();
    chk("done_low", 32'(done), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("final_init", 32'(init_val), 32'(ev));
    chk("hold_fixed", 32'(fixed_cnt), 32'(ef));
    chk("hold_cycle", 32'(cycle_cnt), 32'(ec));
    $display("sweep %0d..%0d mode %0d: %0d loads, fixed %0d cycle %0d", sv, ev, mode, loads,
             fixed_cnt, cycle_cnt);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    start_val = '0;
    end_val = '0;
    fixed = 1'b0;
    cycle = 1'b0;
    #1;
    chk("rst_outputs", 32'({init_val, load, busy, done, fixed_cnt, cycle_cnt}), 32'd0);
    #11 rst_n = 1'b1;
    step();
    chk("idle_after_rst", 32'(busy), 32'd0);
    $display("reset: outputs cleared");

    // basic 3..5 with fixed, cycle, fixed, and extra idle WAIT cycles
    sweep(8'd3, 8'd5, 3, 2, 1'b0);
    repeat (3) step();
    chk("idle_hold_init", 32'(init_val), 32'd5);
    chk("idle_hold_fixed", 32'(fixed_cnt), 32'd2);

    // wrap through 255 -> 0
    sweep(8'd254, 8'd1, 1, 0, 1'b0);
    // single value, both flags, start together with abort
    sweep(8'd7, 8'd7, 2, 0, 1'b1);

    // abort during second WAIT, with a busy start earlier
    start_val = 8'd3;
    end_val = 8'd5;
    start = 1'b1;
    step();
    chk("ab_load", 32'({load, init_val}), 32'({1'b1, 8'd3}));
    start_val = 8'd100;
    step();
    start = 1'b0;
    chk("ab_busy_start_ignored", 32'(init_val), 32'd3);
    chk("ab_counts_cleared", 32'({fixed_cnt, cycle_cnt}), 32'd0);
    fixed = 1'b1;
    step();
    fixed = 1'b0;
    chk("ab_second_load", 32'({load, init_val}), 32'({1'b1, 8'd4}));
    step();
    cycle = 1'b1;
    abort = 1'b1;
    step();
    cycle = 1'b0;
    abort = 1'b0;
    chk("ab_idle", 32'({busy, load, done}), 32'd0);
    chk("ab_fixed_hold", 32'(fixed_cnt), 32'd1);
    chk("ab_cycle_not_counted", 32'(cycle_cnt), 32'd0);
    chk("ab_init_hold", 32'(init_val), 32'd4);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("ab_no_done", 32'({busy, done}), 32'd0);
    end
    $display("abort: fixed %0d cycle %0d init %0d", fixed_cnt, cycle_cnt, init_val);

    // full 256-value sweep
    sweep(8'd0, 8'd255, 0, 0, 1'b0);
    chk("full_cnt_100", 32'(fixed_cnt), 32'h100);

    // reset in the middle of a WAIT
    start_val = 8'd10;
    end_val = 8'd20;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    fixed = 1'b1;
    step();
    fixed = 1'b0;
    step();
    chk("rw_pre_state", 32'({busy, fixed_cnt}), 32'({1'b1, 9'd1}));
    #2 rst_n = 1'b0;
    #1;
    chk("rw_async_clear", 32'({init_val, load, busy, done, fixed_cnt, cycle_cnt}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rw_stay_idle", 32'({busy, done, load}), 32'd0);
    end
    $display("reset mid-wait: outputs cleared, no done");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/init_sweep_ctrl.md
INIT_SWEEP_CTRL -- requirements
Module: init_sweep_ctrl

Interface
REQ-001 The block SHALL have parameter W, default 8, giving the gene-network state width in bits.
REQ-002 The block SHALL have parameter CW, default W+1, giving the width of each result counter.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port start, input, 1 bit: request to begin a sweep, sampled in IDLE only.
REQ-006 The block SHALL have port abort, input, 1 bit: cancel the running sweep.
REQ-007 The block SHALL have port start_val, input, W bits: first initial value of the sweep, captured on start.
REQ-008 The block SHALL have port end_val, input, W bits: last initial value of the sweep, captured on start.
REQ-009 The block SHALL have port fixed, input, 1 bit: network reports a fixed point for the current init_val.
REQ-010 The block SHALL have port cycle, input, 1 bit: network reports a cycle for the current init_val.
REQ-011 The block SHALL have port init_val, output, W bits: initial value presented to the network.
REQ-012 The block SHALL have port load, output, 1 bit: one-cycle pulse telling the network to load init_val.
REQ-013 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-014 The block SHALL have port done, output, 1 bit: one-cycle pulse when a sweep completes normally.
REQ-015 The block SHALL have port fixed_cnt, output, CW bits: number of init values that ended in a fixed point.
REQ-016 The block SHALL have port cycle_cnt, output, CW bits: number of init values that ended in a cycle.

Function
REQ-017 The FSM SHALL have states IDLE, LOAD, WAIT and DONE; all outputs are registered.
REQ-018 In IDLE with start=1, the block SHALL load init_val<=start_val, latch end_val, clear both counters, and go to LOAD.
REQ-019 In IDLE with start=0, the block SHALL hold all outputs.
REQ-020 In LOAD, the block SHALL assert load for exactly one cycle and go to WAIT next cycle.
REQ-021 In LOAD, the block SHALL ignore fixed and cycle.
REQ-022 In WAIT with fixed=0 and cycle=0, the block SHALL remain in WAIT indefinitely.
REQ-023 In WAIT with fixed=1, the block SHALL increment fixed_cnt by 1.
REQ-024 In WAIT with fixed=0 and cycle=1, the block SHALL increment cycle_cnt by 1.
REQ-025 In WAIT with fixed=1 and cycle=1 together, the block SHALL count the value as fixed only.
REQ-026 On a WAIT result with init_val equal to the latched end_val, the block SHALL go to DONE.
REQ-027 On any other WAIT result, the block SHALL set init_val<=init_val+1 modulo 2^W and go to LOAD.
REQ-028 A sweep with start_val>end_val SHALL wrap through 2^W-1 to 0.
REQ-029 A sweep with start_val==end_val SHALL evaluate exactly one value.
REQ-030 A sweep with start_val==end_val+1 (mod 2^W) SHALL evaluate all 2^W values.
REQ-031 Counters SHALL never overflow: with CW=W+1 the maximum count is 2^W.
REQ-032 In DONE, the block SHALL assert done for one cycle and return to IDLE.
REQ-033 In DONE, init_val and both counters SHALL hold their final values until the next start.
REQ-034 abort=1 in LOAD, WAIT or DONE SHALL force IDLE on the next edge with done=0 and load=0.
REQ-035 After abort, the counters and init_val SHALL keep the values they held at the abort edge.
REQ-036 abort SHALL take priority over a simultaneous fixed or cycle: that result is not counted.
REQ-037 start while busy=1 SHALL be ignored.
REQ-038 start and abort together in IDLE SHALL start a sweep; abort has no effect in IDLE.

Reset
REQ-039 rst_n=0 SHALL immediately, without a clock, force IDLE.
REQ-040 rst_n=0 SHALL clear init_val, fixed_cnt, cycle_cnt, load, busy and done to 0.
REQ-041 On rst_n release, the block SHALL act on start no earlier than the first rising clk edge after release.
REQ-042 Reset asserted mid-sweep SHALL discard the sweep; no done pulse is produced.

Verification
REQ-043 Basic sweep, W=8: start_val=3, end_val=5, results fixed, cycle, fixed -> init_val 3,4,5, three load pulses, fixed_cnt=2, cycle_cnt=1, one done pulse, then IDLE.
REQ-044 Wrap: start_val=254, end_val=1, all results cycle -> init_val 254,255,0,1, cycle_cnt=4, fixed_cnt=0.
REQ-045 Simultaneous results: fixed=cycle=1 on a single-value sweep (start_val=end_val=7) -> fixed_cnt=1, cycle_cnt=0, done pulse.
REQ-046 Abort and busy start: abort during the second WAIT of the 3..5 sweep -> IDLE, no done, fixed_cnt and cycle_cnt hold their counts; a start pulsed while busy earlier does not restart the sweep.
REQ-047 Full sweep: start_val=0, end_val=255, all results fixed -> 256 load pulses, fixed_cnt=256 (9'h100), done pulse.
REQ-048 Reset mid-WAIT: rst_n low between edges -> all outputs 0 before the next edge, busy=0, no done.
